note_detect: RTL and testbench
==============================

// Module: note_detect
// PURPOSE
//  Pitch detector: the inverse of the note square-wave generator. Measures the
//  period of an incoming square tone (clk cycles between rising edges), matches it
//  against the 29-entry note table (indices 0..28, C..E over ~2.3 octaves) and
//  reports the note index once it is stable. Sits between a tone input pin or
//  loopback from the generator and the CPU/display logic.
// PARAMETERS
//  CNT_W      20      width of period counter and period output
//  MAX_PERIOD 400000  clocks without a rising edge before signal is declared lost
//  TOL_SHIFT  6       match tolerance: |P - P_k| <= (P_k >> TOL_SHIFT) (~1.56%)
//  STABLE     3       consecutive identical classifications required to update
// PORTS
//  clk          in   1      system clock (50 MHz)
//  reset_n      in   1      asynchronous, active-low reset
//  tonein       in   1      asynchronous square-wave tone input
//  noteout      out  7      detected note index 0..28; 127 = none/unknown
//  note_valid   out  1      1 while noteout holds a valid note
//  note_strobe  out  1      1-cycle pulse whenever noteout or note_valid changes
//  period       out  CNT_W  last measured full period P, in clk cycles
// BEHAVIOUR
//  Reset (async, reset_n=0): noteout=127, note_valid=0, note_strobe=0, period=0,
//   state=SEEK, counter=0, candidate=127, match count=0, synchronisers=0.
//  Input: 2-FF synchroniser + delay reg; rise = s2 & ~d. Fixed input latency.
//  Note table P_k = 2*(DIV_k+1), DIV_k for k=0..28: 191114 180385 170262 160705
//   151686 143173 135136 127552 120389 113636 107259 101239 95558 90194 85132
//   80354 75845 71558 67567 63775 60197 56817 53629 50619 47777 45097 42566
//   40176 37921.
//  Counter cnt: cleared on every rise, else +1 each cycle, runs in all states.
//  FSM:
//   SEEK: wait for rise -> MEASURE (cnt=0).
//   MEASURE: on rise: P=cnt+1 latched to period, cnt=0, k=0 -> CLASSIFY.
//   CLASSIFY: one table entry per cycle, k=0..28 (29 cycles); lowest matching k
//    wins; no match -> result 127. Commit on cycle after k=28, -> MEASURE.
//    A rise during CLASSIFY aborts it: result treated as 127 (mismatch), new
//    measurement starts from that rise (cnt=0, state MEASURE).
//  Commit: result==candidate -> match count +1 (saturate at STABLE); else
//   candidate=result, match count=1. When match count == STABLE after commit:
//   noteout=candidate, note_valid=(candidate!=127); note_strobe pulses only if
//   noteout/note_valid actually changed. Output update = 30 clks after rise.
//  Timeout: cnt reaches MAX_PERIOD in MEASURE/CLASSIFY -> SEEK, noteout=127,
//   note_valid=0, candidate=127, match count=0, strobe if outputs changed;
//   period keeps last value. In SEEK cnt saturates at MAX_PERIOD (no wrap).
//  Arithmetic: |P-P_k| computed unsigned at CNT_W+1 bits; P_k fits in CNT_W.
//  First rise after reset/timeout only starts timing; no period produced.
// TESTING
//  1 Reset; tonein period 227274 (k=9, A) -> after 4th rise +30 clks:
//    noteout=9, note_valid=1, one note_strobe pulse; period=227274.
//  2 Period 229547 (+1%) -> noteout=9 valid; period 234092 (+3%) -> after 3
//    periods noteout=127, note_valid=0, one strobe.
//  3 Steady k=0 (P=382230), switch to P=75844 -> noteout stays 0 for 2 periods,
//    becomes 28 on 3rd measured period, single strobe.
//  4 Lock k=12 then hold tonein high -> MAX_PERIOD clks after last rise:
//    noteout=127, note_valid=0, strobe; period unchanged.
//  5 Alternate periods 227274/214520 -> no update from reset state (127, 0, no
//    strobe); glitch rise during CLASSIFY -> aborted, lock delayed.
//  6 Assert reset_n=0 mid-CLASSIFY with note locked -> all outputs reset values
//    immediately (no clk edge); relock after STABLE+1 rises post-release.

Source files
------------

// File: rtl/note_detect_if.sv
// Tone-detector signal bundle: raw tone input in, note result and period out.
// Latency: none (wires only).
// Backpressure: none; results are level/pulse outputs the consumer samples.
//
// Ports (via modports):
//   master : drives tonein, observes noteout/note_valid/note_strobe/period
//   slave  : the detector itself
interface note_detect_if #(
    parameter int CNT_W = 20
);
    logic             tonein;
    logic [6:0]       noteout;
    logic             note_valid;
    logic             note_strobe;
    logic [CNT_W-1:0] period;

    modport master (
        output tonein,
        input  noteout,
        input  note_valid,
        input  note_strobe,
        input  period
    );

    modport slave (
        input  tonein,
        output noteout,
        output note_valid,
        output note_strobe,
        output period
    );
endinterface

// File: rtl/note_detect.sv
// Pitch detector: measures the period of a square tone and reports which of the 29 table notes it is.
// Latency: outputs update 30 clk after the synchronised rising edge that completes a period.
// Backpressure: none; note_strobe is a single-cycle pulse whenever noteout/note_valid change.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   asynchronous active-low reset
//   det      slave modport of note_detect_if: tonein in; noteout, note_valid,
//            note_strobe, period out
//
// TABLE_SHIFT right-shifts every divider constant before P_k = 2*(DIV_k+1) is
// formed; 0 gives the audio note table for a 50 MHz clock, larger values suit
// proportionally slower clocks or scaled tone rates.
module note_detect #(
    parameter int CNT_W       = 20,
    parameter int MAX_PERIOD  = 400000,
    parameter int TOL_SHIFT   = 6,
    parameter int STABLE      = 3,
    parameter int TABLE_SHIFT = 0
) (
    input  logic          clk,
    input  logic          reset_n,
    note_detect_if.slave  det
);

    localparam int               MC_W     = $clog2(STABLE + 1);
    localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_PERIOD);
    localparam logic [MC_W-1:0]  STABLE_C = MC_W'(STABLE);
    localparam logic [6:0]       NONE     = 7'd127;
    localparam logic [4:0]       K_LAST   = 5'd28;
    localparam logic [4:0]       K_DONE   = 5'd29;

    typedef enum logic [1:0] {
        SEEK     = 2'd0,
        MEASURE  = 2'd1,
        CLASSIFY = 2'd2
    } state_t;

    // Full period in clk cycles for note k (indices above 28 alias note 28).
    function automatic logic [CNT_W-1:0] note_period(input logic [4:0] k);
        logic [17:0] div;
        case (k)
            5'd0:    div = 18'd191114;
            5'd1:    div = 18'd180385;
            5'd2:    div = 18'd170262;
            5'd3:    div = 18'd160705;
            5'd4:    div = 18'd151686;
            5'd5:    div = 18'd143173;
            5'd6:    div = 18'd135136;
            5'd7:    div = 18'd127552;
            5'd8:    div = 18'd120389;
            5'd9:    div = 18'd113636;
            5'd10:   div = 18'd107259;
            5'd11:   div = 18'd101239;
            5'd12:   div = 18'd95558;
            5'd13:   div = 18'd90194;
            5'd14:   div = 18'd85132;
            5'd15:   div = 18'd80354;
            5'd16:   div = 18'd75845;
            5'd17:   div = 18'd71558;
            5'd18:   div = 18'd67567;
            5'd19:   div = 18'd63775;
            5'd20:   div = 18'd60197;
            5'd21:   div = 18'd56817;
            5'd22:   div = 18'd53629;
            5'd23:   div = 18'd50619;
            5'd24:   div = 18'd47777;
            5'd25:   div = 18'd45097;
            5'd26:   div = 18'd42566;
            5'd27:   div = 18'd40176;
            default: div = 18'd37921;
        endcase
        return CNT_W'((({14'd0, div} >> TABLE_SHIFT) + 32'd1) << 1);
    endfunction

    // ---------------------------------------------------------------
    // Input synchroniser and edge detect
    // ---------------------------------------------------------------
    logic sync1_q, sync2_q, dly_q;
    logic rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            dly_q   <= 1'b0;
        end else begin
            sync1_q <= det.tonein;
            sync2_q <= sync1_q;
            dly_q   <= sync2_q;
        end
    end

    assign rise = sync2_q & ~dly_q;

    // ---------------------------------------------------------------
    // Period counter: cleared by every rise, otherwise counts up and
    // parks at MAX_PERIOD so a dead input never wraps into a fake period.
    // ---------------------------------------------------------------
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (rise)
            cnt_d = '0;
        else if (cnt_q < MAX_C)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    // ---------------------------------------------------------------
    // FSM state and registered outputs
    // ---------------------------------------------------------------
    state_t           state_q;
    logic [4:0]       k_q;
    logic [6:0]       result_q;
    logic [6:0]       cand_q;
    logic [MC_W-1:0]  mcnt_q;
    logic [6:0]       noteout_q;
    logic             valid_q;
    logic             strobe_q;
    logic [CNT_W-1:0] period_q;

    // Tolerance test of the measured period against table entry k_q.
    logic [CNT_W-1:0] pk;
    logic [CNT_W:0]   diff;
    logic             hit;

    always_comb begin
        pk   = note_period(k_q);
        diff = ({1'b0, period_q} >= {1'b0, pk}) ? ({1'b0, period_q} - {1'b0, pk})
                                                : ({1'b0, pk} - {1'b0, period_q});
        hit  = (diff <= {1'b0, (pk >> TOL_SHIFT)});
    end

    // Commit of a classification result into the stability filter. An
    // aborted classification commits "no note" so a noisy input cannot lock.
    logic            abort;
    logic            timeout;
    logic [6:0]      commit_res;
    logic [6:0]      cand_d;
    logic [MC_W-1:0] mcnt_d;
    logic [6:0]      note_d;
    logic            valid_d;
    logic            chg;

    always_comb begin
        abort      = (state_q == CLASSIFY) && rise;
        timeout    = (state_q != SEEK) && (cnt_q == MAX_C);
        commit_res = abort ? NONE : result_q;
        cand_d     = cand_q;
        mcnt_d     = mcnt_q;
        if (commit_res == cand_q) begin
            if (mcnt_q < STABLE_C)
                mcnt_d = mcnt_q + MC_W'(1);
        end else begin
            cand_d = commit_res;
            mcnt_d = MC_W'(1);
        end
        note_d  = noteout_q;
        valid_d = valid_q;
        if (mcnt_d == STABLE_C) begin
            note_d  = cand_d;
            valid_d = (cand_d != NONE);
        end
        chg = (note_d != noteout_q) || (valid_d != valid_q);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= SEEK;
            k_q       <= '0;
            result_q  <= NONE;
            cand_q    <= NONE;
            mcnt_q    <= '0;
            noteout_q <= NONE;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            period_q  <= '0;
        end else begin
            strobe_q <= 1'b0;
            if (timeout) begin
                // Signal lost: drop the note but keep the last period.
                state_q   <= SEEK;
                noteout_q <= NONE;
                valid_q   <= 1'b0;
                cand_q    <= NONE;
                mcnt_q    <= '0;
                strobe_q  <= (noteout_q != NONE) || valid_q;
            end else begin
                case (state_q)
                    SEEK: begin
                        // First edge only gives a timing reference.
                        if (rise)
                            state_q <= MEASURE;
                    end
                    MEASURE: begin
                        if (rise) begin
                            period_q <= cnt_q + CNT_W'(1);
                            k_q      <= '0;
                            result_q <= NONE;
                            state_q  <= CLASSIFY;
                        end
                    end
                    CLASSIFY: begin
                        if (rise || (k_q == K_DONE)) begin
                            cand_q    <= cand_d;
                            mcnt_q    <= mcnt_d;
                            noteout_q <= note_d;
                            valid_q   <= valid_d;
                            strobe_q  <= chg;
                            state_q   <= MEASURE;
                        end else begin
                            // Scan upward; the first hit is the lowest index.
                            if (hit && (result_q == NONE) && (k_q <= K_LAST))
                                result_q <= {2'b00, k_q};
                            k_q <= k_q + 5'd1;
                        end
                    end
                    default: state_q <= SEEK;
                endcase
            end
        end
    end

    assign det.noteout     = noteout_q;
    assign det.note_valid  = valid_q;
    assign det.note_strobe = strobe_q;
    assign det.period      = period_q;

endmodule

// File: tb/tb_note_detect.sv
// Bench for note_detect with a scaled note table so full lock/timeout sequences stay short.
// Latency expectations: note result appears between 28 and 40 clk after a tone rising edge.
// Backpressure: none; strobes are counted continuously.
module tb_note_detect;

    localparam int CNT_W = 20;
    localparam int MAX_P = 4000;
    localparam int TOL   = 6;
    localparam int STAB  = 3;
    localparam int TSH   = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    note_detect_if #(.CNT_W(CNT_W)) dif ();

    note_detect #(
        .CNT_W      (CNT_W),
        .MAX_PERIOD (MAX_P),
        .TOL_SHIFT  (TOL),
        .STABLE     (STAB),
        .TABLE_SHIFT(TSH)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .det    (dif)
    );

    int checks = 0;
    int errors = 0;
    int strobe_seen = 0;

    always @(negedge clk) if (dif.note_strobe === 1'b1) strobe_seen++;

    // ---------------- reference model ----------------
    int div_tab [29] = '{191114, 180385, 170262, 160705, 151686, 143173, 135136,
                         127552, 120389, 113636, 107259, 101239, 95558, 90194,
                         85132, 80354, 75845, 71558, 67567, 63775, 60197, 56817,
                         53629, 50619, 47777, 45097, 42566, 40176, 37921};

    int m_note, m_valid, m_cand, m_cnt, m_strobes, m_period, m_meas;
    bit m_have;

    function automatic int tab_p(int k);
        return 2 * ((div_tab[k] >>> TSH) + 1);
    endfunction

    function automatic int classify(int p);
        for (int k = 0; k < 29; k++) begin
            int d;
            d = (p > tab_p(k)) ? p - tab_p(k) : tab_p(k) - p;
            if (d <= (tab_p(k) >>> TOL)) return k;
        end
        return 127;
    endfunction

    task automatic model_reset();
        m_note = 127; m_valid = 0; m_cand = 127; m_cnt = 0;
        m_period = 0; m_have = 0; m_meas = 0;
    endtask

    task automatic model_commit(input int r);
        int nn, nv;
        if (r == m_cand) begin
            if (m_cnt < STAB) m_cnt++;
        end else begin
            m_cand = r;
            m_cnt = 1;
        end
        if (m_cnt == STAB) begin
            nn = m_cand;
            nv = (m_cand != 127) ? 1 : 0;
            if (nn != m_note || nv != m_valid) m_strobes++;
            m_note = nn;
            m_valid = nv;
        end
    endtask

    task automatic model_timeout();
        if (m_note != 127 || m_valid != 0) m_strobes++;
        m_note = 127; m_valid = 0; m_cand = 127; m_cnt = 0; m_have = 0;
    endtask

    task automatic do_reset();
        dif.tonein = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
    endtask

    // One tone period starting with a rising edge; the edge completes the
    // previous period, so outputs are checked against the model afterwards.
    // With glitch set, a second short rise lands while that period is being
    // classified.
    task automatic apply_period(input string tag, input int p, input bit glitch);
        bit         measured, g;
        logic [6:0] exp_n;
        logic       exp_v;
        logic [CNT_W-1:0] exp_p;
        measured = m_have;
        g = glitch && measured;
        exp_n = 7'(m_note);
        exp_v = (m_valid != 0);
        dif.tonein = 1'b1;
        if (measured) begin
            m_period = m_meas;
            model_commit(g ? 127 : classify(m_meas));
        end
        m_have = 1;
        if (g) begin
            repeat (8) @(negedge clk);
            dif.tonein = 1'b0;
            repeat (4) @(negedge clk);
            dif.tonein = 1'b1;
            repeat (28) @(negedge clk);
            m_meas = p - 12;
        end else begin
            repeat (28) @(negedge clk);
            if (measured) begin
                checks++;
                if (dif.noteout !== exp_n || dif.note_valid !== exp_v) begin
                    errors++;
                    $display("FAIL %s early_hold: got note %0d valid %0b, want note %0d valid %0b",
                             tag, dif.noteout, dif.note_valid, exp_n, exp_v);
                end
            end
            repeat (12) @(negedge clk);
            m_meas = p;
        end
        if (measured) begin
            exp_n = 7'(m_note);
            exp_v = (m_valid != 0);
            exp_p = CNT_W'(m_period);
            checks++;
            if (dif.noteout !== exp_n) begin
                errors++;
                $display("FAIL %s noteout: got %0d want %0d", tag, dif.noteout, exp_n);
            end
            checks++;
            if (dif.note_valid !== exp_v) begin
                errors++;
                $display("FAIL %s note_valid: got %0b want %0b", tag, dif.note_valid, exp_v);
            end
            checks++;
            if (dif.period !== exp_p) begin
                errors++;
                $display("FAIL %s period: got %0d want %0d", tag, dif.period, exp_p);
            end
            checks++;
            if (strobe_seen != m_strobes) begin
                errors++;
                $display("FAIL %s strobes: got %0d want %0d", tag, strobe_seen, m_strobes);
            end
        end
        repeat (p / 2 - 40) @(negedge clk);
        dif.tonein = 1'b0;
        repeat (p - p / 2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        dif.tonein = 1'b0;
        reset_n = 1'b0;
        m_strobes = 0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (dif.noteout !== 7'd127) begin
            errors++; $display("FAIL reset noteout: got %0d want 127", dif.noteout);
        end
        checks++;
        if (dif.note_valid !== 1'b0) begin
            errors++; $display("FAIL reset note_valid: got %0b want 0", dif.note_valid);
        end
        checks++;
        if (dif.note_strobe !== 1'b0) begin
            errors++; $display("FAIL reset note_strobe: got %0b want 0", dif.note_strobe);
        end
        checks++;
        if (dif.period !== '0) begin
            errors++; $display("FAIL reset period: got %0d want 0", dif.period);
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_lock();
        int s0;
        s0 = strobe_seen;
        for (int i = 0; i < 4; i++) apply_period("lock", tab_p(9), 1'b0);
        checks++;
        if (dif.noteout !== 7'd9 || dif.note_valid !== 1'b1) begin
            errors++;
            $display("FAIL lock_a: got note %0d valid %0b want 9/1", dif.noteout, dif.note_valid);
        end
        checks++;
        if (strobe_seen - s0 != 1) begin
            errors++; $display("FAIL lock_strobe: got %0d pulses want 1", strobe_seen - s0);
        end
    endtask

    task automatic test_tolerance();
        int s0;
        for (int i = 0; i < 3; i++) apply_period("tol_in", tab_p(9) + 9, 1'b0);
        checks++;
        if (dif.noteout !== 7'd9 || dif.note_valid !== 1'b1) begin
            errors++;
            $display("FAIL tol_in: got note %0d valid %0b want 9/1", dif.noteout, dif.note_valid);
        end
        s0 = strobe_seen;
        for (int i = 0; i < 4; i++) apply_period("tol_out", tab_p(9) + 27, 1'b0);
        checks++;
        if (dif.noteout !== 7'd127 || dif.note_valid !== 1'b0) begin
            errors++;
            $display("FAIL tol_out: got note %0d valid %0b want 127/0", dif.noteout, dif.note_valid);
        end
        checks++;
        if (strobe_seen - s0 != 1) begin
            errors++; $display("FAIL tol_out_strobe: got %0d pulses want 1", strobe_seen - s0);
        end
    endtask

    task automatic test_switch();
        int s0;
        for (int i = 0; i < 4; i++) apply_period("low_note", tab_p(0), 1'b0);
        checks++;
        if (dif.noteout !== 7'd0) begin
            errors++; $display("FAIL switch_pre: got note %0d want 0", dif.noteout);
        end
        s0 = strobe_seen;
        for (int i = 0; i < 4; i++) apply_period("switch", tab_p(28) - 1, 1'b0);
        checks++;
        if (dif.noteout !== 7'd28 || dif.note_valid !== 1'b1) begin
            errors++;
            $display("FAIL switch_post: got note %0d valid %0b want 28/1", dif.noteout, dif.note_valid);
        end
        checks++;
        if (strobe_seen - s0 != 1) begin
            errors++; $display("FAIL switch_strobe: got %0d pulses want 1", strobe_seen - s0);
        end
    endtask

    task automatic test_timeout();
        logic [CNT_W-1:0] p_exp;
        int s0;
        for (int i = 0; i < 4; i++) apply_period("pre_timeout", tab_p(12), 1'b0);
        dif.tonein = 1'b1;
        m_period = m_meas;
        model_commit(classify(m_meas));
        p_exp = CNT_W'(m_period);
        repeat (40) @(negedge clk);
        checks++;
        if (dif.noteout !== 7'd12 || dif.note_valid !== 1'b1) begin
            errors++;
            $display("FAIL timeout_lock: got note %0d valid %0b want 12/1", dif.noteout, dif.note_valid);
        end
        s0 = strobe_seen;
        repeat (MAX_P - 50) @(negedge clk);
        checks++;
        if (dif.note_valid !== 1'b1) begin
            errors++; $display("FAIL timeout_early: got valid %0b want 1", dif.note_valid);
        end
        repeat (20) @(negedge clk);
        model_timeout();
        checks++;
        if (dif.noteout !== 7'd127 || dif.note_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_drop: got note %0d valid %0b want 127/0", dif.noteout, dif.note_valid);
        end
        checks++;
        if (dif.period !== p_exp) begin
            errors++; $display("FAIL timeout_period: got %0d want %0d", dif.period, p_exp);
        end
        checks++;
        if (strobe_seen - s0 != 1 || strobe_seen != m_strobes) begin
            errors++;
            $display("FAIL timeout_strobe: got %0d pulses (total %0d) want 1 (total %0d)",
                     strobe_seen - s0, strobe_seen, m_strobes);
        end
        dif.tonein = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_alternate_glitch();
        int s0;
        do_reset();
        s0 = strobe_seen;
        for (int i = 0; i < 6; i++)
            apply_period("alternate", (i % 2 == 0) ? tab_p(9) : tab_p(10), 1'b0);
        checks++;
        if (dif.noteout !== 7'd127 || dif.note_valid !== 1'b0 || strobe_seen != s0) begin
            errors++;
            $display("FAIL alternate: got note %0d valid %0b pulses %0d want 127/0/0",
                     dif.noteout, dif.note_valid, strobe_seen - s0);
        end
        apply_period("glitch", tab_p(9), 1'b0);
        apply_period("glitch", tab_p(9), 1'b1);
        apply_period("glitch", tab_p(9), 1'b0);
        apply_period("glitch", tab_p(9), 1'b0);
        checks++;
        if (dif.note_valid !== 1'b0) begin
            errors++; $display("FAIL glitch_delay: got valid %0b want 0", dif.note_valid);
        end
        apply_period("glitch", tab_p(9), 1'b0);
        checks++;
        if (dif.noteout !== 7'd9 || dif.note_valid !== 1'b1) begin
            errors++;
            $display("FAIL glitch_lock: got note %0d valid %0b want 9/1", dif.noteout, dif.note_valid);
        end
    endtask

    task automatic test_async_reset();
        dif.tonein = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (dif.noteout !== 7'd127 || dif.note_valid !== 1'b0 ||
            dif.note_strobe !== 1'b0 || dif.period !== '0) begin
            errors++;
            $display("FAIL async_reset: got note %0d valid %0b strobe %0b period %0d want 127/0/0/0",
                     dif.noteout, dif.note_valid, dif.note_strobe, dif.period);
        end
        dif.tonein = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        for (int i = 0; i < STAB + 1; i++) apply_period("relock", tab_p(9), 1'b0);
        checks++;
        if (dif.noteout !== 7'd9 || dif.note_valid !== 1'b1) begin
            errors++;
            $display("FAIL relock: got note %0d valid %0b want 9/1", dif.noteout, dif.note_valid);
        end
    endtask

    task automatic test_random();
        int k, reps, p, pk;
        bit g;
        for (int i = 0; i < 8; i++) begin
            k = int'($urandom_range(0, 28));
            reps = int'($urandom_range(1, 4));
            for (int r = 0; r < reps; r++) begin
                pk = tab_p(k);
                p = pk - pk / 32 + int'($urandom_range(0, pk / 16));
                g = ($urandom_range(0, 7) == 0);
                apply_period("random", p, g);
            end
        end
    endtask

    initial begin
        dif.tonein = 1'b0;
        test_reset();
        test_lock();
        test_tolerance();
        test_switch();
        test_timeout();
        test_alternate_glitch();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
